// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 hex keypad scanner.
// Holds state encodings, matrix dimensions and the full-scan classifier.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        ONE   = 2'd1,
        MULTI = 2'd2
    } scan_class_e;

    typedef struct packed {
        scan_class_e cls;
        logic [3:0]  code;
    } scan_result_t;

    // Bit (4*row + col) of pressed is set when that key was seen low during the scan.
    function automatic scan_result_t classify(input logic [15:0] pressed);
        scan_result_t res;
        int           n;
        n        = 0;
        res.code = 4'd0;
        for (int i = 0; i < NUM_ROWS * NUM_COLS; i++) begin
            if (pressed[i]) begin
                n++;
                res.code = 4'(i);
            end
        end
        if (n == 0) begin
            res.cls = NONE;
        end else if (n == 1) begin
            res.cls = ONE;
        end else begin
            res.cls = MULTI;
        end
        return res;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchroniser for the asynchronous, active-low keypad row lines.
// Resets to all-ones so an idle keypad reads as "no row pulled low".
module keypad_row_sync (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] row_sync
);

    logic [3:0] meta_q, meta_d;
    logic [3:0] sync_q, sync_d;

    always_comb begin
        meta_d = row_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            meta_q <= 4'b1111;
            sync_q <= 4'b1111;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign row_sync = sync_q;

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner: drives columns, classifies each full scan and
// debounces presses/releases, shifting accepted digits into a 16-bit value.
module hex_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        clr,
    input  logic [3:0]  row_in,
    output logic [3:0]  col_out,
    output logic [15:0] value,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

    logic [3:0]       rows_s;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [15:0]      scan_q, scan_d;
    state_e           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [15:0]      value_q, value_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             col_last;
    logic             scan_end;
    logic             accept;
    scan_result_t     scan_res;

    keypad_row_sync u_row_sync (
        .clk_in   (clk_in),
        .reset    (reset),
        .row_in   (row_in),
        .row_sync (rows_s)
    );

    // Rows are only trusted on the last cycle of a column, after the sync delay.
    always_comb begin
        col_last = (div_q == DIV_LAST);
        scan_end = col_last && (col_q == 2'd3);
        div_d    = col_last ? '0 : div_q + 1'b1;
        col_d    = col_last ? col_q + 2'd1 : col_q;
        scan_d   = scan_q;
        if (col_last) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                scan_d[{2'(r), col_q}] = ~rows_s[r];
            end
        end
        scan_res = classify(scan_d);
    end

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 1'b1;
        accept  = 1'b0;
        if (scan_end) begin
            unique case (state_q)
                IDLE: begin
                    if (scan_res.cls == ONE) begin
                        cand_d = scan_res.code;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                        end else begin
                            state_d = PRESS_DB;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                PRESS_DB: begin
                    if (scan_res.cls == ONE && scan_res.code == cand_q) begin
                        if (cnt_inc == CNT_TARGET) begin
                            accept  = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (scan_res.cls == NONE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RELEASE_DB;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                RELEASE_DB: begin
                    if (scan_res.cls == NONE) begin
                        if (cnt_inc == CNT_TARGET) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // clr beats a simultaneous accept for value, but the pulse and code still happen.
        key_valid_d = accept;
        key_code_d  = accept ? cand_d : key_code_q;
        if (clr) begin
            value_d = '0;
        end else if (accept) begin
            value_d = {value_q[11:0], cand_d};
        end else begin
            value_d = value_q;
        end
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            div_q       <= '0;
            col_q       <= '0;
            scan_q      <= '0;
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            value_q     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            col_q       <= col_d;
            scan_q      <= scan_d;
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            value_q     <= value_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign col_out   = ~(4'b0001 << col_q);
    assign value     = value_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = (state_q == HELD) || (state_q == RELEASE_DB);

endmodule

// File: tb/tb_hex_keypad_scanner.sv
// Self-checking bench for hex_keypad_scanner: a keypad model pulls rows low for
// pressed keys, and a scan-level debounce model predicts the expected outputs.
module tb_hex_keypad_scanner;

    localparam int SCAN_DIV       = 4;
    localparam int DB             = 2;
    localparam int SCAN_CYCLES    = 4 * SCAN_DIV;

    logic        clk_in;
    logic        reset;
    logic        clr;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [15:0] value;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] keys;

    int checks;
    int errors;
    int pulse_count;

    bit          m_held;
    bit          m_accept;
    int          m_streak;
    int          m_streak_key;
    int          m_empty;
    logic [15:0] m_value;
    logic [3:0]  m_code;
    int          m_pulses;

    hex_keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DB)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .clr       (clr),
        .row_in    (row_in),
        .col_out   (col_out),
        .value     (value),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Physical keypad: a pressed key shorts its row to its column while that column is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r + c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    always @(negedge clk_in) begin
        if (reset && key_valid) pulse_count++;
    end

    task automatic model_reset();
        m_held       = 1'b0;
        m_accept     = 1'b0;
        m_streak     = 0;
        m_streak_key = -1;
        m_empty      = 0;
        m_value      = 16'h0000;
        m_code       = 4'h0;
    endtask

    // Scan-level model: DB identical single-key scans accept, DB empty scans release.
    task automatic model_scan(input logic [15:0] k, input int clr_cycle);
        int n;
        int key;
        n   = $countones(k);
        key = -1;
        for (int i = 0; i < 16; i++) if (k[i]) key = i;
        m_accept = 1'b0;
        if (clr_cycle >= 0 && clr_cycle < SCAN_CYCLES - 1) m_value = 16'h0000;
        if (!m_held) begin
            if (n == 1) begin
                if (m_streak > 0 && key == m_streak_key) begin
                    m_streak++;
                end else if (m_streak > 0) begin
                    m_streak = 0;
                end else begin
                    m_streak     = 1;
                    m_streak_key = key;
                end
                if (m_streak == DB) begin
                    m_accept = 1'b1;
                    m_held   = 1'b1;
                    m_streak = 0;
                    m_empty  = 0;
                    m_code   = 4'(key);
                    m_value  = (m_value << 4) | 16'(key);
                    m_pulses++;
                end
            end else begin
                m_streak = 0;
            end
        end else begin
            if (n == 0) begin
                m_empty++;
                if (m_empty == DB) begin
                    m_held  = 1'b0;
                    m_empty = 0;
                end
            end else begin
                m_empty = 0;
            end
        end
        if (clr_cycle == SCAN_CYCLES - 1) m_value = 16'h0000;
    endtask

    // Entered at the negedge that opens column 0; returns at the negedge after scan end.
    task automatic do_scan(input logic [15:0] k, input int clr_cycle);
        keys = k;
        for (int i = 0; i < SCAN_CYCLES; i++) begin
            clr = (i == clr_cycle);
            @(negedge clk_in);
        end
        clr = 1'b0;
        model_scan(k, clr_cycle);
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        keys  = 16'h0000;
        clr   = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk_in);
        checks++;
        if ({col_out, value, key_code, key_valid, key_held} !== {4'b1110, 16'h0, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got col=%b val=%h code=%h v=%b h=%b, expected col=1110 val=0000 code=0 v=0 h=0",
                     col_out, value, key_code, key_valid, key_held);
        end
        reset = 1'b1;
        for (int i = 0; i < 7 * SCAN_CYCLES; i++) begin
            exp_col = ~(4'b0001 << ((i / SCAN_DIV) % 4));
            checks++;
            if (col_out !== exp_col) begin
                errors++;
                $display("[TB] FAIL idle_col cycle %0d: got %b expected %b", i, col_out, exp_col);
            end
            checks++;
            if ({key_valid, key_held, value} !== {1'b0, 1'b0, 16'h0}) begin
                errors++;
                $display("[TB] FAIL idle_outputs cycle %0d: got v=%b h=%b val=%h expected v=0 h=0 val=0000",
                         i, key_valid, key_held, value);
            end
            @(negedge clk_in);
        end
        checks++;
        if (pulse_count !== 0) begin
            errors++;
            $display("[TB] FAIL idle_pulses: got %0d expected 0", pulse_count);
        end
    endtask

    task automatic test_single_key();
        int p0;
        p0 = pulse_count;
        for (int s = 0; s < 10; s++) begin
            do_scan((s < 6) ? 16'h0040 : 16'h0000, -1);
            checks++;
            if ({key_valid, key_held, key_code, value} !== {m_accept, m_held, m_code, m_value}) begin
                errors++;
                $display("[TB] FAIL single_scan%0d: got v=%b h=%b code=%h val=%h expected v=%b h=%b code=%h val=%h",
                         s, key_valid, key_held, key_code, value, m_accept, m_held, m_code, m_value);
            end
            if (s == 5) begin
                checks++;
                if ({key_held, key_code, value} !== {1'b1, 4'h6, 16'h0006}) begin
                    errors++;
                    $display("[TB] FAIL single_held: got h=%b code=%h val=%h expected h=1 code=6 val=0006",
                             key_held, key_code, value);
                end
            end
            if (s == 6 || s == 7) begin
                checks++;
                if (key_held !== (s == 6)) begin
                    errors++;
                    $display("[TB] FAIL single_release%0d: got h=%b expected h=%b", s - 5, key_held, (s == 6));
                end
            end
        end
        checks++;
        if (pulse_count - p0 !== 1) begin
            errors++;
            $display("[TB] FAIL single_pulses: got %0d expected 1", pulse_count - p0);
        end
    endtask

    task automatic test_sequence();
        int p0;
        p0 = pulse_count;
        for (int k = 1; k <= 5; k++) begin
            for (int s = 0; s < 8; s++) begin
                do_scan((s < 4) ? (16'h0001 << k) : 16'h0000, -1);
                checks++;
                if ({key_valid, key_held, key_code, value} !== {m_accept, m_held, m_code, m_value}) begin
                    errors++;
                    $display("[TB] FAIL seq_key%0d_scan%0d: got v=%b h=%b code=%h val=%h expected v=%b h=%b code=%h val=%h",
                             k, s, key_valid, key_held, key_code, value, m_accept, m_held, m_code, m_value);
                end
            end
        end
        checks++;
        if (value !== 16'h2345 || pulse_count - p0 !== 5) begin
            errors++;
            $display("[TB] FAIL seq_final: got val=%h pulses=%0d expected val=2345 pulses=5", value, pulse_count - p0);
        end
    endtask

    task automatic test_bounce();
        int          p0;
        logic [15:0] v0;
        p0 = pulse_count;
        v0 = value;
        for (int s = 0; s < 10; s++) begin
            do_scan((s % 2 == 0) ? 16'h0400 : 16'h0000, -1);
            checks++;
            if ({key_valid, key_held, value} !== {m_accept, m_held, m_value}) begin
                errors++;
                $display("[TB] FAIL bounce_scan%0d: got v=%b h=%b val=%h expected v=%b h=%b val=%h",
                         s, key_valid, key_held, value, m_accept, m_held, m_value);
            end
        end
        checks++;
        if (pulse_count != p0 || value !== v0) begin
            errors++;
            $display("[TB] FAIL bounce_result: got pulses=%0d val=%h expected pulses=0 val=%h", pulse_count - p0, value, v0);
        end
    endtask

    task automatic test_multi_key();
        int          p0;
        logic [15:0] pattern [0:13];
        p0 = pulse_count;
        for (int s = 0; s < 14; s++) begin
            if (s < 4)       pattern[s] = 16'h1008;
            else if (s < 6)  pattern[s] = 16'h0008;
            else if (s < 10) pattern[s] = 16'h1008;
            else             pattern[s] = 16'h0000;
        end
        for (int s = 0; s < 14; s++) begin
            do_scan(pattern[s], -1);
            checks++;
            if ({key_valid, key_held, key_code, value} !== {m_accept, m_held, m_code, m_value}) begin
                errors++;
                $display("[TB] FAIL multi_scan%0d: got v=%b h=%b code=%h val=%h expected v=%b h=%b code=%h val=%h",
                         s, key_valid, key_held, key_code, value, m_accept, m_held, m_code, m_value);
            end
            if (s >= 6 && s < 10) begin
                checks++;
                if (key_held !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL multi_held_scan%0d: got h=%b expected h=1", s, key_held);
                end
            end
        end
        checks++;
        if (pulse_count - p0 !== 1 || key_code !== 4'h3) begin
            errors++;
            $display("[TB] FAIL multi_result: got pulses=%0d code=%h expected pulses=1 code=3", pulse_count - p0, key_code);
        end
    endtask

    task automatic test_clr();
        for (int k = 1; k <= 4; k++) begin
            for (int s = 0; s < 4; s++) do_scan((s < 2) ? (16'h0001 << k) : 16'h0000, -1);
        end
        checks++;
        if (value !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL clr_setup: got val=%h expected val=1234", value);
        end
        do_scan(16'h8000, -1);
        do_scan(16'h8000, SCAN_CYCLES - 1);
        checks++;
        if ({key_valid, key_code, value} !== {1'b1, 4'hF, 16'h0000}) begin
            errors++;
            $display("[TB] FAIL clr_with_accept: got v=%b code=%h val=%h expected v=1 code=f val=0000",
                     key_valid, key_code, value);
        end
        for (int s = 0; s < 2; s++) do_scan(16'h0000, -1);
        for (int s = 0; s < 2; s++) do_scan(16'h0080, -1);
        checks++;
        if (value !== 16'h0007) begin
            errors++;
            $display("[TB] FAIL clr_pre_alone: got val=%h expected val=0007", value);
        end
        do_scan(16'h0080, 5);
        checks++;
        if ({key_held, key_code, value} !== {1'b1, 4'h7, 16'h0000} || value !== m_value) begin
            errors++;
            $display("[TB] FAIL clr_alone: got h=%b code=%h val=%h expected h=1 code=7 val=0000",
                     key_held, key_code, value);
        end
        for (int s = 0; s < 2; s++) do_scan(16'h0000, -1);
    endtask

    task automatic test_reset_mid();
        for (int s = 0; s < 2; s++) do_scan(16'h0020, -1);
        for (int s = 0; s < 2; s++) do_scan(16'h0000, -1);
        do_scan(16'h0200, -1);
        repeat (6) @(negedge clk_in);
        reset = 1'b0;
        #1;
        checks++;
        if ({col_out, value, key_code, key_valid, key_held} !== {4'b1110, 16'h0, 4'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_mid: got col=%b val=%h code=%h v=%b h=%b expected col=1110 val=0000 code=0 v=0 h=0",
                     col_out, value, key_code, key_valid, key_held);
        end
        repeat (2) @(negedge clk_in);
        reset = 1'b1;
        model_reset();
        for (int s = 0; s < 2; s++) begin
            do_scan(16'h0200, -1);
            checks++;
            if ({key_valid, key_held, key_code, value} !== {m_accept, m_held, m_code, m_value}) begin
                errors++;
                $display("[TB] FAIL reset_redetect_scan%0d: got v=%b h=%b code=%h val=%h expected v=%b h=%b code=%h val=%h",
                         s, key_valid, key_held, key_code, value, m_accept, m_held, m_code, m_value);
            end
        end
        for (int s = 0; s < 2; s++) do_scan(16'h0000, -1);
    endtask

    task automatic test_random();
        logic [15:0] cur;
        int          mode;
        int          a;
        int          b;
        cur = 16'h0000;
        for (int round = 0; round < 30; round++) begin
            mode = $urandom_range(0, 3);
            a    = $urandom_range(0, 15);
            b    = (a + $urandom_range(1, 15)) % 16;
            case (mode)
                0:       cur = 16'h0000;
                1:       cur = 16'h0001 << a;
                2:       cur = cur;
                default: cur = (16'h0001 << a) | (16'h0001 << b);
            endcase
            for (int s = 0; s < $urandom_range(1, 3); s++) begin
                do_scan(cur, ($urandom_range(0, 9) == 0) ? $urandom_range(0, SCAN_CYCLES - 1) : -1);
                checks++;
                if ({key_valid, key_held, key_code, value} !== {m_accept, m_held, m_code, m_value}) begin
                    errors++;
                    $display("[TB] FAIL random_r%0d_s%0d keys=%h: got v=%b h=%b code=%h val=%h expected v=%b h=%b code=%h val=%h",
                             round, s, cur, key_valid, key_held, key_code, value, m_accept, m_held, m_code, m_value);
                end
            end
        end
        checks++;
        if (pulse_count !== m_pulses) begin
            errors++;
            $display("[TB] FAIL total_pulses: got %0d expected %0d", pulse_count, m_pulses);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        pulse_count = 0;
        m_pulses    = 0;
        test_reset();
        test_single_key();
        test_sequence();
        test_bounce();
        test_multi_key();
        test_clr();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_keypad_scanner.md
Name: hex_keypad_scanner

Overview:
Scans a 4x4 matrix hex keypad and debounces it. Each accepted key press is shifted into a 16-bit entry register, so the board has an input path alongside the seg7x16 output path. The 16-bit value feeds the pcpu/dmem data side, or the display for echo. One clock domain (clk_in); the keypad pins are asynchronous and are synchronised internally.

Parameters:
SCAN_DIV, 100000, clk_in cycles each column is driven; must be >= 4
DEBOUNCE_SCANS, 4, consecutive identical full scans needed to accept a press or a release; must be >= 1

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous, active-low reset
clr  input  1  synchronous clear of value, active-high
row_in  input  4  keypad row sense, active-low, asynchronous
col_out  output  4  keypad column drive, active-low, one-hot-zero
value  output  16  last four accepted hex digits, newest in [3:0]
key_code  output  4  code of the most recently accepted key
key_valid  output  1  one-cycle pulse on each accepted press
key_held  output  1  high while an accepted key is not yet released

Behaviour:
- Reset values (while reset=0, asynchronous): col_out=4'b1110; value=0; key_code=0; key_valid=0; key_held=0; FSM=IDLE; all counters=0.
- Synchroniser: row_in passes through 2 flops before use.
- Column sequence: columns cycle 0,1,2,3,0,… Column c is driven low (col_out[c]=0, all other bits 1) for SCAN_DIV cycles.
- Row sampling: synced rows are sampled on the last cycle of each column period, so they have settled.
- Scan result: one full scan = 4 column periods. At the end of column 3 the scan is classified as:
  - NONE: no row low in any column.
  - ONE(code): exactly one (row r, column c) low; code = 4*r + c, giving 0x0..0xF.
  - MULTI: two or more keys low.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB. Transitions are evaluated only at scan end.
  - IDLE: ONE(k) -> PRESS_DB with cand=k, cnt=1. If DEBOUNCE_SCANS=1, accept immediately and go to HELD. NONE or MULTI -> stay in IDLE.
  - PRESS_DB: ONE(cand) -> cnt+1; when cnt reaches DEBOUNCE_SCANS, accept and go to HELD. ONE(other), NONE or MULTI -> IDLE, cnt=0.
  - HELD: NONE -> RELEASE_DB, cnt=1 (or straight to IDLE if DEBOUNCE_SCANS=1). ONE or MULTI -> stay in HELD; no new entry while held (no auto-repeat, no rollover).
  - RELEASE_DB: NONE -> cnt+1; when cnt reaches DEBOUNCE_SCANS, go to IDLE. ONE or MULTI -> back to HELD, cnt=0.
- Accept, in the single cycle after the qualifying scan end:
  - key_valid=1 for exactly one cycle;
  - key_code=cand;
  - value={value[11:0],cand}.
- key_held=1 in HELD and RELEASE_DB, 0 otherwise.
- Latency: for a key held from scan boundary 0, key_valid asserts DEBOUNCE_SCANS*4*SCAN_DIV+1 cycles later, plus 2 cycles of synchroniser skew already absorbed in sampling.
- Wrap-around: value is a shift register; the fifth digit pushes the oldest digit out of [15:12]. Column and divider counters wrap freely.
- clr, simultaneous events:
  - clr alone sets value=0 next cycle and does not affect FSM, key_code or key_held.
  - clr in the same cycle as an accept: clr wins, value=0, but key_valid still pulses and key_code updates.
- Reset mid-operation: everything returns to the reset values immediately. A key still held after reset is released is re-detected from IDLE and accepted again after a full debounce.

Decomposition:
- Shared package keypad_pkg holds:
  - state encoding constants (IDLE=2'd0, PRESS_DB=2'd1, HELD=2'd2, RELEASE_DB=2'd3);
  - NUM_COLS=4 and NUM_ROWS=4;
  - scan-result classes NONE/ONE/MULTI.
- One sub-module: keypad_row_sync, a 4-bit, 2-flop synchroniser with asynchronous active-low reset to 4'b1111.
- The column timer, scan classifier and FSM stay in the top module.

Test Plan:
(Bench model: a keypad that pulls row r low while col_out[c]=0 for each pressed key. Parameters SCAN_DIV=4, DEBOUNCE_SCANS=2.)
- Reset, then idle for 100 cycles -> col_out repeats 1110,1101,1011,0111 with 4 cycles per column; value=0, key_valid never asserts, key_held=0.
- Press key (r=1, c=2) and hold for 6 scans -> exactly one key_valid pulse; key_code=0x6, value=0x0006, key_held=1; key_held falls 2 scans after release.
- Press 0x1, 0x2, 0x3, 0x4, 0x5 in turn, each held 4 scans with 4 scans released between -> five pulses; final value=0x2345.
- Bounce: key 0xA present in 1 scan, absent in the next, repeated for 10 scans -> no key_valid, value unchanged.
- Two keys (0x3 and 0xC) held together from idle -> no accept. Hold 0x3 until accepted, then add 0xC -> no second pulse and key_held stays 1.
- Assert clr on the same cycle as the accept of key 0xF with value=0x1234 -> value=0x0000, key_valid=1, key_code=0xF. Pull reset low mid-PRESS_DB -> all outputs return to their reset values.
